// File: rtl/ntt_pkg.sv
// Shared constants, state encoding and helpers for the forward/inverse NTT engines.
package ntt_pkg;

  localparam int unsigned N_DEF      = 32;
  localparam int unsigned COEF_W_DEF = 4;
  localparam int unsigned Q_W_DEF    = 8;
  localparam int unsigned IDX_W_DEF  = $clog2(N_DEF);

  // Frame sequencing states, kept as plain constants for legacy tool flows.
  typedef logic [1:0] state_t;
  localparam state_t ST_LOAD  = 2'd0;
  localparam state_t ST_MAC   = 2'd1;
  localparam state_t ST_SCALE = 2'd2;
  localparam state_t ST_OUT   = 2'd3;

  // Index counter width; a 1-bit counter still works for the smallest frame.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // x mod m, with a modulus below 2 collapsing everything to zero.
  function automatic logic [15:0] mod_reduce(input logic [15:0] x, input logic [15:0] m);
    if (m < 16'd2) return 16'd0;
    return x % m;
  endfunction

endpackage

// File: rtl/intt_serial_if.sv
// Stream bundle for the inverse NTT engine: coefficient input and result output.
interface intt_serial_if
  import ntt_pkg::*;
#(
  parameter int unsigned COEF_W = COEF_W_DEF
) ();

  logic              s_valid;
  logic              s_ready;
  logic [COEF_W-1:0] s_data;
  logic              m_valid;
  logic              m_ready;
  logic [COEF_W-1:0] m_data;
  logic              m_last;

  // Environment side: produces input beats, consumes results.
  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data, m_last
  );

  // Engine side.
  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data, m_last
  );

endinterface

// File: rtl/modmul.sv
// Combinational (a*b + c) mod q on residue-width operands.
module modmul #(
  parameter int unsigned COEF_W = 4,
  parameter int unsigned Q_W    = 8
) (
  input  logic [COEF_W-1:0] a,
  input  logic [COEF_W-1:0] b,
  input  logic [COEF_W-1:0] c,
  input  logic [Q_W-1:0]    q,
  output logic [COEF_W-1:0] y
);

  localparam int unsigned ProdW = 2 * COEF_W + 1;
  localparam int unsigned W     = (ProdW > Q_W) ? ProdW : Q_W;

  logic [W-1:0] sum;
  logic [W-1:0] q_ext;
  logic [W-1:0] rem;

  // Full-width product plus addend, then a single reduction; q < 2 yields 0.
  always_comb begin
    sum   = W'(a) * W'(b) + W'(c);
    q_ext = W'(q);
    rem   = '0;
    if (q_ext >= W'(2)) begin
      rem = sum % q_ext;
    end
    y = COEF_W'(rem);
  end

endmodule

// File: rtl/intt_serial.sv
// Serial inverse NTT: buffers N residues, evaluates each output with one MAC term per
// cycle, scales by n_inv and streams results in index order.
module intt_serial
  import ntt_pkg::*;
#(
  parameter int unsigned N      = N_DEF,
  parameter int unsigned COEF_W = COEF_W_DEF,
  parameter int unsigned Q_W    = Q_W_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [Q_W-1:0] q,
  input  logic [Q_W-1:0] w_inv,
  input  logic [Q_W-1:0] n_inv,
  output logic           busy,
  intt_serial_if.slave   bus
);

  localparam int unsigned     IdxW = idx_width(N);
  localparam logic [IdxW-1:0] Last = IdxW'(N - 1);

  state_t            state_q, state_d;
  logic [IdxW-1:0]   j_q, j_d;
  logic [IdxW-1:0]   i_q, i_d;
  logic [Q_W-1:0]    q_q, q_d;
  logic [COEF_W-1:0] w_q, w_d;
  logic [COEF_W-1:0] n_q, n_d;
  logic [COEF_W-1:0] r_q, r_d;
  logic [COEF_W-1:0] tw_q, tw_d;
  logic [COEF_W-1:0] acc_q, acc_d;
  logic [COEF_W-1:0] m_data_q, m_data_d;
  logic              m_valid_q, m_valid_d;
  logic              m_last_q, m_last_d;

  logic [COEF_W-1:0] buf_q [N];
  logic              buf_we;
  logic [COEF_W-1:0] buf_wdata;
  logic [Q_W-1:0]    q_sel;

  // The accumulate/scale path and the power path each need a product in the same MAC
  // cycle, so there is one multiplier per path, each time-shared across states.
  logic [COEF_W-1:0] acc_a, acc_b, acc_c, acc_y;
  logic [COEF_W-1:0] pw_a, pw_b, pw_y;

  modmul #(
    .COEF_W (COEF_W),
    .Q_W    (Q_W)
  ) u_acc_mul (
    .a (acc_a),
    .b (acc_b),
    .c (acc_c),
    .q (q_q),
    .y (acc_y)
  );

  modmul #(
    .COEF_W (COEF_W),
    .Q_W    (Q_W)
  ) u_pow_mul (
    .a (pw_a),
    .b (pw_b),
    .c ('0),
    .q (q_q),
    .y (pw_y)
  );

  // First beat of a frame reduces against the live q port; later beats use the latched one.
  assign q_sel     = (j_q == '0) ? q : q_q;
  assign buf_wdata = COEF_W'(mod_reduce(16'(bus.s_data), 16'(q_sel)));

  // Next-state and datapath steering per FSM state.
  always_comb begin
    state_d   = state_q;
    j_d       = j_q;
    i_d       = i_q;
    q_d       = q_q;
    w_d       = w_q;
    n_d       = n_q;
    r_d       = r_q;
    tw_d      = tw_q;
    acc_d     = acc_q;
    m_data_d  = m_data_q;
    m_valid_d = m_valid_q;
    m_last_d  = m_last_q;
    buf_we    = 1'b0;
    acc_a     = '0;
    acc_b     = '0;
    acc_c     = '0;
    pw_a      = '0;
    pw_b      = '0;

    unique case (state_q)
      ST_LOAD: begin
        if (bus.s_valid) begin
          buf_we = 1'b1;
          j_d    = j_q + 1'b1;
          if (j_q == '0) begin
            q_d = q;
            w_d = COEF_W'(mod_reduce(16'(w_inv), 16'(q)));
            n_d = COEF_W'(mod_reduce(16'(n_inv), 16'(q)));
          end
          if (j_q == Last) begin
            state_d = ST_MAC;
            j_d     = '0;
            i_d     = '0;
            r_d     = COEF_W'(1);
            tw_d    = COEF_W'(1);
            acc_d   = '0;
          end
        end
      end
      ST_MAC: begin
        acc_a = buf_q[j_q];
        acc_b = tw_q;
        acc_c = acc_q;
        acc_d = acc_y;
        // Twiddle advances by repeated multiplication so non-roots stay exact.
        pw_a  = tw_q;
        pw_b  = r_q;
        tw_d  = pw_y;
        j_d   = j_q + 1'b1;
        if (j_q == Last) begin
          state_d = ST_SCALE;
          j_d     = '0;
        end
      end
      ST_SCALE: begin
        acc_a     = acc_q;
        acc_b     = n_q;
        m_data_d  = acc_y;
        m_valid_d = 1'b1;
        m_last_d  = (i_q == Last);
        state_d   = ST_OUT;
      end
      ST_OUT: begin
        if (bus.m_ready) begin
          m_valid_d = 1'b0;
          m_last_d  = 1'b0;
          if (i_q != Last) begin
            i_d     = i_q + 1'b1;
            pw_a    = r_q;
            pw_b    = w_q;
            r_d     = pw_y;
            acc_d   = '0;
            tw_d    = COEF_W'(1);
            state_d = ST_MAC;
          end else begin
            j_d     = '0;
            state_d = ST_LOAD;
          end
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  // Control and arithmetic state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_LOAD;
      j_q       <= '0;
      i_q       <= '0;
      q_q       <= '0;
      w_q       <= '0;
      n_q       <= '0;
      r_q       <= '0;
      tw_q      <= '0;
      acc_q     <= '0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      j_q       <= j_d;
      i_q       <= i_d;
      q_q       <= q_d;
      w_q       <= w_d;
      n_q       <= n_d;
      r_q       <= r_d;
      tw_q      <= tw_d;
      acc_q     <= acc_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
    end
  end

  // Coefficient buffer; contents are only meaningful after a full LOAD, so no reset.
  always_ff @(posedge clk) begin
    if (buf_we) begin
      buf_q[j_q] <= buf_wdata;
    end
  end

  assign bus.s_ready = (state_q == ST_LOAD);
  assign bus.m_valid = m_valid_q;
  assign bus.m_data  = m_data_q;
  assign bus.m_last  = m_last_q;
  assign busy        = !((state_q == ST_LOAD) && (j_q == '0));

endmodule

// File: tb/tb_intt_serial.sv
// Self-checking bench for intt_serial against a direct-formula inverse NTT model.
module tb_intt_serial;
  import ntt_pkg::*;

  typedef logic [COEF_W_DEF-1:0] frame_t [N_DEF];

  logic               clk;
  logic               rst_n;
  logic [Q_W_DEF-1:0] q;
  logic [Q_W_DEF-1:0] w_inv;
  logic [Q_W_DEF-1:0] n_inv;
  logic               busy;
  int                 checks;
  int                 errors;

  intt_serial_if #(.COEF_W(COEF_W_DEF)) dut_if ();

  intt_serial #(
    .N      (N_DEF),
    .COEF_W (COEF_W_DEF),
    .Q_W    (Q_W_DEF)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .q     (q),
    .w_inv (w_inv),
    .n_inv (n_inv),
    .busy  (busy),
    .bus   (dut_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // b^e mod m by plain repeated multiplication (m >= 2).
  function automatic int pow_mod(input int b, input int e, input int m);
    int r;
    r = 1;
    for (int k = 0; k < e; k++) r = (r * b) % m;
    return r;
  endfunction

  // out[i] = n_inv * sum_j in[j] * w_inv^(i*j) mod q, inputs reduced mod q first.
  function automatic void intt_model(input frame_t x, input int qv, input int wv, input int nv,
                                     output frame_t y);
    int s;
    for (int i = 0; i < N_DEF; i++) y[i] = '0;
    if (qv < 2) return;
    for (int i = 0; i < N_DEF; i++) begin
      s = 0;
      for (int j = 0; j < N_DEF; j++)
        s = (s + (int'(x[j]) % qv) * pow_mod(wv % qv, i * j, qv)) % qv;
      y[i] = COEF_W_DEF'((s * (nv % qv)) % qv);
    end
  endfunction

  // Forward transform golden model: X[k] = sum_j x[j] * w^(j*k) mod q.
  function automatic void fwd_model(input frame_t x, input int qv, input int wv,
                                    output frame_t y);
    int s;
    for (int k = 0; k < N_DEF; k++) begin
      s = 0;
      for (int j = 0; j < N_DEF; j++) s = (s + int'(x[j]) * pow_mod(wv, j * k, qv)) % qv;
      y[k] = COEF_W_DEF'(s);
    end
  endfunction

  task automatic do_reset();
    rst_n          = 1'b0;
    dut_if.s_valid = 1'b0;
    dut_if.s_data  = '0;
    dut_if.m_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic send_frame(input frame_t x, input int qv, input int wv, input int nv,
                            input bit jitter, input string tag);
    for (int j = 0; j < N_DEF; j++) begin
      @(negedge clk);
      checks++;
      if (dut_if.s_ready !== 1'b1 || dut_if.m_valid !== 1'b0) begin
        errors++;
        $display("FAIL %s load_beat %0d: s_ready=%b m_valid=%b, want 1 0", tag, j,
                 dut_if.s_ready, dut_if.m_valid);
      end
      checks++;
      if (busy !== (j > 0)) begin
        errors++;
        $display("FAIL %s busy_load %0d: got %b want %b", tag, j, busy, (j > 0));
      end
      dut_if.s_valid = 1'b1;
      dut_if.s_data  = x[j];
      if (j == 0 || !jitter) begin
        q     = Q_W_DEF'(qv);
        w_inv = Q_W_DEF'(wv);
        n_inv = Q_W_DEF'(nv);
      end else begin
        q     = Q_W_DEF'($urandom_range(0, 255));
        w_inv = Q_W_DEF'($urandom_range(0, 255));
        n_inv = Q_W_DEF'($urandom_range(0, 255));
      end
    end
    @(posedge clk);
    #1;
    dut_if.s_valid = 1'b0;
  endtask

  task automatic collect(input frame_t e, input int n_out, input bit bp, input bit chk_lat,
                         input string tag);
    int waited;
    bit done;
    bit stalled;
    logic [COEF_W_DEF-1:0] held;
    for (int i = 0; i < n_out; i++) begin
      waited  = 0;
      done    = 1'b0;
      stalled = 1'b0;
      held    = '0;
      while (!done) begin
        @(negedge clk);
        waited++;
        checks++;
        if (dut_if.s_ready !== 1'b0) begin
          errors++;
          $display("FAIL %s s_ready_busy out %0d: got %b want 0", tag, i, dut_if.s_ready);
        end
        if (stalled) begin
          checks++;
          if (dut_if.m_valid !== 1'b1 || dut_if.m_data !== held) begin
            errors++;
            $display("FAIL %s hold out %0d: valid=%b data=%0d, want 1 %0d", tag, i,
                     dut_if.m_valid, dut_if.m_data, held);
          end
        end
        if (dut_if.m_valid === 1'b1) begin
          if (!stalled) begin
            checks++;
            if (dut_if.m_data !== e[i]) begin
              errors++;
              $display("FAIL %s data out %0d: got %0d want %0d", tag, i, dut_if.m_data, e[i]);
            end
            checks++;
            if (dut_if.m_last !== (i == N_DEF - 1)) begin
              errors++;
              $display("FAIL %s last out %0d: got %b want %b", tag, i, dut_if.m_last,
                       (i == N_DEF - 1));
            end
            if (chk_lat) begin
              checks++;
              if (waited != N_DEF + 2) begin
                errors++;
                $display("FAIL %s latency out %0d: got %0d want %0d", tag, i, waited,
                         N_DEF + 2);
              end
            end
          end
          held           = dut_if.m_data;
          dut_if.m_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
          stalled        = !dut_if.m_ready;
          done           = dut_if.m_ready;
        end else begin
          stalled        = 1'b0;
          dut_if.m_ready = bp ? 1'($urandom_range(0, 1)) : 1'b0;
          if (waited > 4 * N_DEF + 16) begin
            errors++;
            $display("FAIL %s timeout out %0d: waited %0d cycles, want valid", tag, i, waited);
            return;
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (dut_if.s_ready !== 1'b1 || dut_if.m_valid !== 1'b0 || dut_if.m_last !== 1'b0 ||
        dut_if.m_data !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: rdy=%b vld=%b last=%b data=%0d busy=%b, want 1 0 0 0 0",
               dut_if.s_ready, dut_if.m_valid, dut_if.m_last, dut_if.m_data, busy);
    end
  endtask

  task automatic test_impulse();
    frame_t x, e;
    for (int j = 0; j < N_DEF; j++) x[j] = '0;
    x[0] = 4'd3;
    intt_model(x, 5, 4, 3, e);
    send_frame(x, 5, 4, 3, 1'b0, "impulse");
    collect(e, N_DEF, 1'b0, 1'b1, "impulse");
  endtask

  task automatic test_constant();
    frame_t x, e;
    for (int j = 0; j < N_DEF; j++) x[j] = 4'd1;
    intt_model(x, 5, 1, 3, e);
    send_frame(x, 5, 1, 3, 1'b0, "constant");
    collect(e, N_DEF, 1'b0, 1'b0, "constant");
  endtask

  task automatic test_shifted(input bit bp);
    frame_t x, e;
    for (int j = 0; j < N_DEF; j++) x[j] = '0;
    x[1] = 4'd1;
    intt_model(x, 5, 4, 3, e);
    send_frame(x, 5, 4, 3, 1'b0, bp ? "backpressure" : "shifted");
    collect(e, N_DEF, bp, 1'b0, bp ? "backpressure" : "shifted");
  endtask

  task automatic test_reset_mid_mac();
    frame_t x, e;
    for (int j = 0; j < N_DEF; j++) x[j] = 4'd1;
    intt_model(x, 5, 1, 3, e);
    send_frame(x, 5, 1, 3, 1'b0, "rst_mid");
    collect(e, 5, 1'b0, 1'b0, "rst_mid");
    dut_if.m_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (dut_if.m_valid !== 1'b0 || dut_if.s_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid after_reset: vld=%b rdy=%b busy=%b, want 0 1 0",
               dut_if.m_valid, dut_if.s_ready, busy);
    end
    rst_n = 1'b1;
    send_frame(x, 5, 1, 3, 1'b0, "rst_new");
    collect(e, N_DEF, 1'b0, 1'b0, "rst_new");
  endtask

  task automatic test_round_trip();
    frame_t x, f, e;
    for (int j = 0; j < N_DEF; j++) x[j] = COEF_W_DEF'($urandom_range(0, 4));
    fwd_model(x, 5, 4, f);
    intt_model(f, 5, 4, 3, e);
    // Parameter ports wander after the first beat; only the first-beat values may count.
    send_frame(f, 5, 4, 3, 1'b1, "round_trip");
    collect(e, N_DEF, 1'b0, 1'b0, "round_trip");
  endtask

  task automatic test_random();
    frame_t x, e;
    int qv, wv, nv;
    for (int k = 0; k < 3; k++) begin
      qv = (k == 0) ? 1 : (k == 1) ? 16 : int'($urandom_range(2, 15));
      wv = int'($urandom_range(0, 255));
      nv = int'($urandom_range(0, 255));
      for (int j = 0; j < N_DEF; j++) x[j] = COEF_W_DEF'($urandom_range(0, 15));
      intt_model(x, qv, wv, nv, e);
      send_frame(x, qv, wv, nv, 1'b0, "random");
      collect(e, N_DEF, (k == 2), 1'b0, "random");
    end
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    rst_n          = 1'b0;
    q              = '0;
    w_inv          = '0;
    n_inv          = '0;
    dut_if.s_valid = 1'b0;
    dut_if.s_data  = '0;
    dut_if.m_ready = 1'b0;
    test_reset();
    test_impulse();
    test_constant();
    test_shifted(1'b0);
    test_shifted(1'b1);
    test_reset_mid_mac();
    test_round_trip();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
